hog_bank_wr_arbiter_tpg: RTL
============================

// Module: hog_bank_wr_arbiter_tpg
// PURPOSE
//  Parametrised successor to the 4-bank fixed write-port select in front of the IMG_top BRAM banks.
//  Arbitrates N_BANKS BRAM write ports between the HOG result writer (priority) and the initial-image loader.
//  A colliding loader write is parked in a per-bank skid register and replayed, so it is never dropped.
//  Also hosts the pixel test-pattern generator that feeds hog_top p/p_valid: passthrough, ramp, constant, checker.
// PARAMETERS
//  N_BANKS     4    number of BRAM banks / write ports
//  RAM_AW      17   BRAM address width
//  DW          8    BRAM data / pixel width
//  IMG_WIDTH   136  pixels per row, used by checker mode
//  RAMP_BITS   5    ramp counter bits passed to p_out; upper bits are zero
//  CNT_W       16   width of each per-bank collision counter
// PORTS
//  aclk          in   1                 clock
//  rst           in   1                 synchronous reset, active-high
//  res_en        in   N_BANKS           HOG result write request, one bit per bank
//  res_we        in   N_BANKS           HOG result write strobe
//  res_addr      in   N_BANKS*RAM_AW    HOG result address, bank b at [b*RAM_AW +: RAM_AW]
//  res_din       in   N_BANKS*DW        HOG result data
//  init_en       in   N_BANKS           loader request; accepted only when init_ready is high
//  init_we       in   N_BANKS           loader write strobe
//  init_addr     in   N_BANKS*RAM_AW    loader address
//  init_din      in   N_BANKS*DW        loader data
//  init_ready    out  N_BANKS           loader may present a request to this bank
//  bram_en       out  N_BANKS           registered BRAM port-A enable
//  bram_we       out  N_BANKS           registered BRAM port-A write enable
//  bram_addr     out  N_BANKS*RAM_AW    registered BRAM port-A address
//  bram_din      out  N_BANKS*DW        registered BRAM port-A data
//  coll_cnt      out  N_BANKS*CNT_W     per-bank count of parked loader writes, saturating
//  clr_cnt       in   1                 synchronous clear of all coll_cnt
//  tp_mode       in   2                 0 passthrough, 1 ramp, 2 constant, 3 checker
//  tp_const      in   DW                value used in constant mode; checker "high" value
//  p_in          in   DW                scaler pixel
//  p_in_valid    in   1                 scaler pixel valid
//  frame_done    in   1                 scaling-finish pulse
//  p_out         out  DW                pixel to HOG
//  p_out_valid   out  1                 pixel valid to HOG
// BEHAVIOUR
//  Reset: all outputs 0 except init_ready, which is all 1; hold regs empty; ramp and column counters 0.
//  Per bank b, evaluated every cycle. Latency is 1 cycle from the selected input to the bram_* registers.
//   - res_en=1: drive res_*. If init_en=1 and init_ready=1 in the same cycle, capture
//     init_we/addr/din into hold[b], set hold_v[b], and increment coll_cnt[b].
//   - res_en=0, hold_v=1: drive hold[b] with en=1 and clear hold_v. A loader request this cycle is not accepted,
//     because init_ready is low.
//   - res_en=0, hold_v=0: drive init_en/we/addr/din directly; bram_en=0 when init_en=0.
//   - init_ready[b] = ~hold_v[b], combinational from the register. A loader holding init_en while ready=0 keeps
//     its request stable.
//   - While res_en stays high, hold persists; replay happens on the first cycle with res_en=0.
//  coll_cnt saturates at 2^CNT_W-1. clr_cnt has priority over a same-cycle increment; the result is 0.
//  Pattern generator, registered with 1-cycle latency. p_out_valid = p_in_valid delayed 1 cycle in every mode.
//   - mode 0: p_out = p_in.
//   - mode 1: p_out = {0, ramp[RAMP_BITS-1:0]}. The ramp increments on each p_in_valid and wraps at 2^RAMP_BITS.
//   - mode 2: p_out = tp_const.
//   - mode 3: p_out = tp_const when col[0]^row[0] is 1, else 0.
//     col increments on each p_in_valid and wraps IMG_WIDTH-1 -> 0; row toggles on each col wrap.
//   - frame_done clears ramp, col and row the next cycle. If p_in_valid is high in the same cycle, that pixel uses
//     the old counters and the counters end at 0.
//   - A tp_mode change takes effect on the next valid pixel; the counters are not cleared by a mode change.
//  Reset asserted mid-operation: any parked hold write is discarded, and bram_en is 0 on the following cycle.
// TESTING
//  1 Bank 2: init_en pulse, addr=0x10, din=0xA5, with res_en=0 -> next cycle bram_en[2]=1, addr=0x10, din=0xA5.
//  2 Bank 0: res_en and init_en together (res addr 5, init addr 9) -> cycle+1 writes addr 5 and init_ready[0]=0;
//    res_en drops -> next cycle writes addr 9, init_ready returns to 1, coll_cnt[0]=1.
//  3 Bank 1: res_en held 10 cycles while one init is parked -> no init write during those cycles;
//    replay lands exactly 1 cycle after res_en falls; no loss and no duplicate.
//  4 CNT_W=2: 5 collisions -> coll_cnt=3; clr_cnt in the same cycle as a collision -> 0.
//  5 mode 1, 40 valid pixels -> p_out 0..31,0..7; frame_done -> next pixel 0.
//  6 mode 3, IMG_WIDTH=4, tp_const=0xFF, 8 pixels -> 00 FF 00 FF FF 00 FF 00; rst mid-hold -> bram_en=0, hold empty.

Source files
------------

// File: rtl/hog_bank_wr_arbiter_tpg.sv
// Per-bank BRAM write-port arbiter (HOG results win, colliding loader writes are parked and replayed)
// plus the pixel test-pattern generator that feeds hog_top.
module hog_bank_wr_arbiter_tpg #(
    parameter int unsigned N_BANKS   = 4,
    parameter int unsigned RAM_AW    = 17,
    parameter int unsigned DW        = 8,
    parameter int unsigned IMG_WIDTH = 136,
    parameter int unsigned RAMP_BITS = 5,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                        aclk,
    input  logic                        rst,
    input  logic [N_BANKS-1:0]          res_en,
    input  logic [N_BANKS-1:0]          res_we,
    input  logic [N_BANKS*RAM_AW-1:0]   res_addr,
    input  logic [N_BANKS*DW-1:0]       res_din,
    input  logic [N_BANKS-1:0]          init_en,
    input  logic [N_BANKS-1:0]          init_we,
    input  logic [N_BANKS*RAM_AW-1:0]   init_addr,
    input  logic [N_BANKS*DW-1:0]       init_din,
    output logic [N_BANKS-1:0]          init_ready,
    output logic [N_BANKS-1:0]          bram_en,
    output logic [N_BANKS-1:0]          bram_we,
    output logic [N_BANKS*RAM_AW-1:0]   bram_addr,
    output logic [N_BANKS*DW-1:0]       bram_din,
    output logic [N_BANKS*CNT_W-1:0]    coll_cnt,
    input  logic                        clr_cnt,
    input  logic [1:0]                  tp_mode,
    input  logic [DW-1:0]               tp_const,
    input  logic [DW-1:0]               p_in,
    input  logic                        p_in_valid,
    input  logic                        frame_done,
    output logic [DW-1:0]               p_out,
    output logic                        p_out_valid
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam int unsigned      COL_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

    logic [N_BANKS-1:0]        hold_v_q,    hold_v_d;
    logic [N_BANKS-1:0]        hold_we_q,   hold_we_d;
    logic [N_BANKS*RAM_AW-1:0] hold_addr_q, hold_addr_d;
    logic [N_BANKS*DW-1:0]     hold_din_q,  hold_din_d;
    logic [N_BANKS-1:0]        bram_en_q,   bram_en_d;
    logic [N_BANKS-1:0]        bram_we_q,   bram_we_d;
    logic [N_BANKS*RAM_AW-1:0] bram_addr_q, bram_addr_d;
    logic [N_BANKS*DW-1:0]     bram_din_q,  bram_din_d;
    logic [N_BANKS*CNT_W-1:0]  coll_cnt_q,  coll_cnt_d;

    logic [RAMP_BITS-1:0]      ramp_q,      ramp_d;
    logic [COL_W-1:0]          col_q,       col_d;
    logic                      row_q,       row_d;
    logic [DW-1:0]             p_out_q,     p_out_d;
    logic                      p_out_valid_q;

    // A bank only accepts a loader request while its skid register is empty.
    assign init_ready = ~hold_v_q;

    always_comb begin
        hold_v_d    = hold_v_q;
        hold_we_d   = hold_we_q;
        hold_addr_d = hold_addr_q;
        hold_din_d  = hold_din_q;
        bram_en_d   = bram_en_q;
        bram_we_d   = bram_we_q;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        coll_cnt_d  = coll_cnt_q;
        for (int unsigned b = 0; b < N_BANKS; b++) begin
            if (res_en[b]) begin
                bram_en_d[b]                     = 1'b1;
                bram_we_d[b]                     = res_we[b];
                bram_addr_d[b*RAM_AW +: RAM_AW]  = res_addr[b*RAM_AW +: RAM_AW];
                bram_din_d[b*DW +: DW]           = res_din[b*DW +: DW];
                if (init_en[b] && !hold_v_q[b]) begin
                    hold_v_d[b]                     = 1'b1;
                    hold_we_d[b]                    = init_we[b];
                    hold_addr_d[b*RAM_AW +: RAM_AW] = init_addr[b*RAM_AW +: RAM_AW];
                    hold_din_d[b*DW +: DW]          = init_din[b*DW +: DW];
                    if (coll_cnt_q[b*CNT_W +: CNT_W] != CNT_MAX)
                        coll_cnt_d[b*CNT_W +: CNT_W] = coll_cnt_q[b*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end else if (hold_v_q[b]) begin
                bram_en_d[b]                     = 1'b1;
                bram_we_d[b]                     = hold_we_q[b];
                bram_addr_d[b*RAM_AW +: RAM_AW]  = hold_addr_q[b*RAM_AW +: RAM_AW];
                bram_din_d[b*DW +: DW]           = hold_din_q[b*DW +: DW];
                hold_v_d[b]                      = 1'b0;
            end else begin
                bram_en_d[b]                     = init_en[b];
                bram_we_d[b]                     = init_we[b];
                bram_addr_d[b*RAM_AW +: RAM_AW]  = init_addr[b*RAM_AW +: RAM_AW];
                bram_din_d[b*DW +: DW]           = init_din[b*DW +: DW];
            end
            if (clr_cnt)
                coll_cnt_d[b*CNT_W +: CNT_W] = '0;
        end
    end

    // Pattern value is computed from the counters as they stand before this pixel advances them.
    always_comb begin
        case (tp_mode)
            2'd0:    p_out_d = p_in;
            2'd1:    p_out_d = DW'(ramp_q);
            2'd2:    p_out_d = tp_const;
            default: p_out_d = (col_q[0] ^ row_q) ? tp_const : '0;
        endcase
        ramp_d = ramp_q;
        col_d  = col_q;
        row_d  = row_q;
        if (p_in_valid) begin
            ramp_d = ramp_q + RAMP_BITS'(1);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = ~row_q;
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
        if (frame_done) begin
            ramp_d = '0;
            col_d  = '0;
            row_d  = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            hold_v_q      <= '0;
            hold_we_q     <= '0;
            hold_addr_q   <= '0;
            hold_din_q    <= '0;
            bram_en_q     <= '0;
            bram_we_q     <= '0;
            bram_addr_q   <= '0;
            bram_din_q    <= '0;
            coll_cnt_q    <= '0;
            ramp_q        <= '0;
            col_q         <= '0;
            row_q         <= 1'b0;
            p_out_q       <= '0;
            p_out_valid_q <= 1'b0;
        end else begin
            hold_v_q      <= hold_v_d;
            hold_we_q     <= hold_we_d;
            hold_addr_q   <= hold_addr_d;
            hold_din_q    <= hold_din_d;
            bram_en_q     <= bram_en_d;
            bram_we_q     <= bram_we_d;
            bram_addr_q   <= bram_addr_d;
            bram_din_q    <= bram_din_d;
            coll_cnt_q    <= coll_cnt_d;
            ramp_q        <= ramp_d;
            col_q         <= col_d;
            row_q         <= row_d;
            p_out_q       <= p_out_d;
            p_out_valid_q <= p_in_valid;
        end
    end

    assign bram_en     = bram_en_q;
    assign bram_we     = bram_we_q;
    assign bram_addr   = bram_addr_q;
    assign bram_din    = bram_din_q;
    assign coll_cnt    = coll_cnt_q;
    assign p_out       = p_out_q;
    assign p_out_valid = p_out_valid_q;

endmodule
